glitch_sweep_seq: RTL and testbench
===================================

// Module: glitch_sweep_seq
// PURPOSE
//  Parametrised reset+glitch sequencer for the Wii U modchip. Sweeps a 2-D grid of
//  glitch delay (after target reset release) x glitch length, one attempt per run.
//  Watches the 8-bit debug GPIO bus for a success code. Emits a per-attempt report
//  record over a valid/ready handshake to the UART queue.
// PARAMETERS
//  CW         16      width of delay/length/timer counters
//  RESET_LEN  16      cycles rst_out_n is held low per attempt (>=1)
//  DLY_MIN    1       first delay of sweep (cycles after reset release)
//  DLY_MAX    16'h300 last delay of sweep (inclusive)
//  DLY_STEP   1       delay increment per attempt (>=1)
//  LEN_MIN    16'h180 first glitch length (>=1)
//  LEN_MAX    16'h200 last glitch length (inclusive)
//  SETTLE_LEN 24'hF0000 cycles watched for success after glitch ends
//  HIT_CODE   8'h88   dbg_in value that marks a successful glitch
//  STOP_ON_HIT 1      1: enter DONE on hit; 0: report and keep sweeping
// PORTS
//  CLK        in   1       system clock
//  RST_N      in   1       asynchronous active-low reset
//  start      in   1       pulse: begin one attempt (IDLE only)
//  abort      in   1       level: force IDLE, release outputs
//  sweep_clr  in   1       pulse in IDLE: reload dly/len to DLY_MIN/LEN_MIN
//  dbg_in     in   8       asynchronous debug GPIO bus from target
//  rst_out_n  out  1       target reset, active low
//  glitch_out out  1       glitch MOSFET drive, active high
//  busy       out  1       high in any state except IDLE/DONE
//  done       out  1       high in DONE
//  wrapped    out  1       sticky: full grid completed at least once
//  rpt_valid  out  1       report record valid
//  rpt_ready  in   1       report consumer ready
//  rpt_data   out  1+2*CW  {hit, len_cur, dly_cur}
// BEHAVIOUR
//  Reset: rst_out_n=1, glitch_out=0, busy=0, done=0, wrapped=0, rpt_valid=0,
//   rpt_data=0, dly_cur=DLY_MIN, len_cur=LEN_MIN, state IDLE.
//  dbg_in passes through a 2-flop synchroniser; hit compare uses the 2nd flop.
//  FSM: IDLE -start-> RST(RESET_LEN cyc, rst_out_n=0) -> WAIT(dly_cur cyc)
//   -> GLITCH(len_cur cyc, glitch_out=1) -> SETTLE(SETTLE_LEN cyc) -> REPORT -> IDLE|DONE.
//  Latency: the first glitch_out=1 cycle is exactly RESET_LEN+dly_cur cycles after
//   the first rst_out_n=0 cycle. dly_cur=0 means GLITCH directly follows RST.
//  Hit: latched if synced dbg_in==HIT_CODE in any GLITCH or SETTLE cycle.
//   Cleared on RST entry. A hit ends SETTLE early (next cycle -> REPORT).
//  REPORT: rpt_valid=1, rpt_data stable until the rpt_valid&&rpt_ready cycle.
//   On that cycle: rpt_valid drops next cycle, then the sweep advances:
//   - If hit&&STOP_ON_HIT: go to DONE, no advance. DONE holds rst_out_n=1,
//     glitch_out=0. DONE is left only via abort.
//   - Otherwise dly_nxt = dly_cur+DLY_STEP, computed in CW+1 bits (no overflow).
//     If dly_nxt>DLY_MAX: dly_cur=DLY_MIN and len_cur+=1.
//     If len_cur==LEN_MAX: len_cur=LEN_MIN and wrapped=1.
//  start outside IDLE is ignored. sweep_clr outside IDLE is ignored.
//   start and sweep_clr in the same cycle: clr applies first; the attempt uses min values.
//  abort: in any state, the next cycle is IDLE with rst_out_n=1, glitch_out=0,
//   rpt_valid=0 and hit cleared. dly/len are unchanged, so a mid-attempt abort
//   repeats the same point. abort has priority over start.
//  RST_N low mid-attempt: all outputs return asynchronously to reset values.
// CONFIGURATION
//  GLITCH_SWEEP_SEQ_AUTORUN_EN defined:
//   IDLE self-starts an attempt 1 cycle after entry, unless abort is high.
//   start is still accepted. Sweeping runs unattended until DONE or abort.
//  Undefined: attempts start only on start. No autorun logic is compiled in.
// TESTING
//  1 RESET_LEN=4,DLY_MIN=3,LEN_MIN=2, start -> rst_out_n low 4 cyc,
//    glitch_out high exactly 2 cyc beginning 7 cyc after first rst_out_n low.
//  2 DLY_MIN=1,DLY_MAX=3,STEP=2,LEN_MIN=5,LEN_MAX=6, 4 attempts with rpt_ready=1
//    -> rpt_data (dly,len) = (1,5),(3,5),(1,6),(3,6); wrapped=1 after the 4th.
//  3 dbg_in=HIT_CODE during GLITCH, STOP_ON_HIT=1 -> REPORT hit=1, then done=1,
//    start ignored, dly/len unchanged; abort -> IDLE, done=0.
//  4 rpt_ready=0 for 10 cyc in REPORT -> rpt_valid and rpt_data stable;
//    advance occurs only on the ready cycle.
//  5 abort asserted mid-GLITCH -> glitch_out=0 and rst_out_n=1 the next cycle;
//    the restarted attempt reuses the same dly/len.
//  6 AUTORUN_EN defined, rpt_ready=1 -> back-to-back attempts without start;
//    RST_N pulse mid-WAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/glitch_sweep_seq.sv
// Reset+glitch sequencer: sweeps a delay x length grid, one attempt per run, reports each attempt.
// Latency: first glitch cycle is RESET_LEN+dly_cur cycles after first rst_out_n low cycle.
// Backpressure: REPORT holds rpt_valid/rpt_data until rpt_ready; sweep advances only on handshake.
// Option: define GLITCH_SWEEP_SEQ_AUTORUN_EN to self-start attempts from IDLE.
module glitch_sweep_seq #(
  parameter int unsigned    CW          = 16,
  parameter int unsigned    RESET_LEN   = 16,
  parameter logic [CW-1:0]  DLY_MIN     = 16'd1,
  parameter logic [CW-1:0]  DLY_MAX     = 16'h300,
  parameter logic [CW-1:0]  DLY_STEP    = 16'd1,
  parameter logic [CW-1:0]  LEN_MIN     = 16'h180,
  parameter logic [CW-1:0]  LEN_MAX     = 16'h200,
  parameter int unsigned    SETTLE_LEN  = 32'hF0000,
  parameter logic [7:0]     HIT_CODE    = 8'h88,
  parameter bit             STOP_ON_HIT = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          sweep_clr_i,
  input  logic [7:0]    dbg_in_i,
  output logic          rst_out_n_o,
  output logic          glitch_out_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          wrapped_o,
  output logic          rpt_valid_o,
  input  logic          rpt_ready_i,
  output logic [2*CW:0] rpt_data_o
);

  // Timer must hold the longest of the phase lengths.
  localparam int unsigned SW  = $clog2(SETTLE_LEN + 1);
  localparam int unsigned RW  = $clog2(RESET_LEN + 1);
  localparam int unsigned MW  = (SW > RW) ? SW : RW;
  localparam int unsigned TW  = (MW > CW) ? MW : CW;
  localparam logic [TW-1:0] RST_LOAD    = TW'(RESET_LEN - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_WAIT, S_GLITCH, S_SETTLE, S_REPORT, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] dly_q, dly_d;
  logic [CW-1:0] len_q, len_d;
  logic          hit_q, hit_d;
  logic          wrapped_q, wrapped_d;
  logic [7:0]    sync1_q, sync2_q;

  logic          hit_now;
  logic          timer_zero;
  logic          go;
  logic [CW:0]   dly_nxt;

  // Two-flop synchroniser for the asynchronous debug bus.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= dbg_in_i;
      sync2_q <= sync1_q;
    end
  end

  // FSM state, phase timer, sweep position and sticky flags.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      dly_q     <= DLY_MIN;
      len_q     <= LEN_MIN;
      hit_q     <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      dly_q     <= dly_d;
      len_q     <= len_d;
      hit_q     <= hit_d;
      wrapped_q <= wrapped_d;
    end
  end

  // Next-state: phase sequencing, hit capture and sweep advance on report handshake.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    dly_d      = dly_q;
    len_d      = len_q;
    hit_d      = hit_q;
    wrapped_d  = wrapped_q;
    hit_now    = (sync2_q == HIT_CODE) && ((state_q == S_GLITCH) || (state_q == S_SETTLE));
    timer_zero = (timer_q == '0);
    dly_nxt    = {1'b0, dly_q} + {1'b0, DLY_STEP};
`ifdef GLITCH_SWEEP_SEQ_AUTORUN_EN
    go         = 1'b1;
`else
    go         = start_i;
`endif

    if (abort_i) begin
      // Sweep position is left alone so the aborted point is retried.
      state_d = S_IDLE;
      hit_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sweep_clr_i) begin
            dly_d = DLY_MIN;
            len_d = LEN_MIN;
          end
          if (go || start_i) begin
            state_d = S_RST;
            timer_d = RST_LOAD;
            hit_d   = 1'b0;
          end
        end
        S_RST: begin
          if (!timer_zero) begin
            timer_d = timer_q - 1'b1;
          end else if (dly_q == '0) begin
            state_d = S_GLITCH;
            timer_d = TW'(len_q) - TW'(1);
          end else begin
            state_d = S_WAIT;
            timer_d = TW'(dly_q) - TW'(1);
          end
        end
        S_WAIT: begin
          if (!timer_zero) begin
            timer_d = timer_q - 1'b1;
          end else begin
            state_d = S_GLITCH;
            timer_d = TW'(len_q) - TW'(1);
          end
        end
        S_GLITCH: begin
          hit_d = hit_q | hit_now;
          if (!timer_zero) begin
            timer_d = timer_q - 1'b1;
          end else begin
            state_d = S_SETTLE;
            timer_d = SETTLE_LOAD;
          end
        end
        S_SETTLE: begin
          hit_d = hit_q | hit_now;
          if (hit_q || hit_now || timer_zero) begin
            state_d = S_REPORT;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        S_REPORT: begin
          if (rpt_ready_i) begin
            if (hit_q && STOP_ON_HIT) begin
              state_d = S_DONE;
            end else begin
              state_d = S_IDLE;
              if (dly_nxt > {1'b0, DLY_MAX}) begin
                dly_d = DLY_MIN;
                if (len_q == LEN_MAX) begin
                  len_d     = LEN_MIN;
                  wrapped_d = 1'b1;
                end else begin
                  len_d = len_q + 1'b1;
                end
              end else begin
                dly_d = dly_nxt[CW-1:0];
              end
            end
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode directly from state so abort and reset take effect without extra delay.
  assign rst_out_n_o  = (state_q != S_RST);
  assign glitch_out_o = (state_q == S_GLITCH);
  assign busy_o       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o       = (state_q == S_DONE);
  assign wrapped_o    = wrapped_q;
  assign rpt_valid_o  = (state_q == S_REPORT);
  assign rpt_data_o   = (state_q == S_REPORT) ? {hit_q, len_q, dly_q} : '0;

endmodule

// File: tb/tb_glitch_sweep_seq.sv
// Directed bench for glitch_sweep_seq using a small grid (dly 1..3 step 2, len 5..6).
// Latency: checks cycle-accurate reset/glitch timing and report contents.
// Backpressure: holds rpt_ready low to confirm report stability and single advance.
module tb_glitch_sweep_seq;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        sweep_clr_i = 1'b0;
  logic [7:0]  dbg_in_i = 8'h00;
  logic        rpt_ready_i = 1'b1;
  logic        rst_out_n_o;
  logic        glitch_out_o;
  logic        busy_o;
  logic        done_o;
  logic        wrapped_o;
  logic        rpt_valid_o;
  logic [32:0] rpt_data_o;

  int n_cmp = 0;
  int n_fail = 0;

  glitch_sweep_seq #(
    .CW(16), .RESET_LEN(4), .DLY_MIN(16'd1), .DLY_MAX(16'd3), .DLY_STEP(16'd2),
    .LEN_MIN(16'd5), .LEN_MAX(16'd6), .SETTLE_LEN(8), .HIT_CODE(8'h88), .STOP_ON_HIT(1'b1)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .abort_i(abort_i),
    .sweep_clr_i(sweep_clr_i), .dbg_in_i(dbg_in_i), .rst_out_n_o(rst_out_n_o),
    .glitch_out_o(glitch_out_o), .busy_o(busy_o), .done_o(done_o), .wrapped_o(wrapped_o),
    .rpt_valid_o(rpt_valid_o), .rpt_ready_i(rpt_ready_i), .rpt_data_o(rpt_data_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [32:0] mk(input logic hit, input int len, input int dly);
    return {hit, 16'(len), 16'(dly)};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Stimulus helper: runs one attempt with rpt_ready high and measures its timing.
  task automatic run_attempt(input bit clr, output logic [32:0] data, output int nrst,
                             output int ngl, output int gap, output bit tmo);
    int first_rst;
    int first_gl;
    bit fin;
    nrst = 0; ngl = 0; first_rst = -1; first_gl = -1; tmo = 1'b1; data = '0; fin = 1'b0;
    rpt_ready_i = 1'b1;
    start_i = 1'b1;
    sweep_clr_i = clr;
    step();
    start_i = 1'b0;
    sweep_clr_i = 1'b0;
    for (int c = 0; c < 200 && !fin; c++) begin
      if (!rst_out_n_o) begin
        if (first_rst < 0) first_rst = c;
        nrst++;
      end
      if (glitch_out_o) begin
        if (first_gl < 0) first_gl = c;
        ngl++;
      end
      if (rpt_valid_o) begin
        data = rpt_data_o;
        tmo = 1'b0;
        fin = 1'b1;
      end
      step();
    end
    gap = first_gl - first_rst;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_cmp++; if (rst_out_n_o !== 1'b1) begin n_fail++; $display("FAIL reset_rst_out_n got %b want 1", rst_out_n_o); end
    n_cmp++; if (glitch_out_o !== 1'b0) begin n_fail++; $display("FAIL reset_glitch got %b want 0", glitch_out_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done_o); end
    n_cmp++; if (wrapped_o !== 1'b0) begin n_fail++; $display("FAIL reset_wrapped got %b want 0", wrapped_o); end
    n_cmp++; if (rpt_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rpt_valid got %b want 0", rpt_valid_o); end
    n_cmp++; if (rpt_data_o !== 33'h0) begin n_fail++; $display("FAIL reset_rpt_data got %h want 0", rpt_data_o); end
    rst_n_i = 1'b1;
    step();
  endtask

  task automatic test_latency();
    logic [32:0] d; int nr, ng, gap; bit tmo;
    run_attempt(1'b0, d, nr, ng, gap, tmo);
    n_cmp++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL lat_timeout got %b want 0", tmo); end
    n_cmp++; if (nr != 4) begin n_fail++; $display("FAIL lat_rst_cycles got %0d want 4", nr); end
    n_cmp++; if (ng != 5) begin n_fail++; $display("FAIL lat_glitch_cycles got %0d want 5", ng); end
    n_cmp++; if (gap != 5) begin n_fail++; $display("FAIL lat_gap got %0d want 5", gap); end
    n_cmp++; if (d !== mk(1'b0, 5, 1)) begin n_fail++; $display("FAIL lat_rpt got %h want %h", d, mk(1'b0, 5, 1)); end
    n_cmp++; if (wrapped_o !== 1'b0) begin n_fail++; $display("FAIL lat_wrapped got %b want 0", wrapped_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL lat_busy_after got %b want 0", busy_o); end
  endtask

  task automatic test_sweep();
    logic [32:0] exp_d [3];
    logic        exp_w [3];
    logic [32:0] d; int nr, ng, gap; bit tmo;
    exp_d[0] = mk(1'b0, 5, 3); exp_w[0] = 1'b0;
    exp_d[1] = mk(1'b0, 6, 1); exp_w[1] = 1'b0;
    exp_d[2] = mk(1'b0, 6, 3); exp_w[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_attempt(1'b0, d, nr, ng, gap, tmo);
      n_cmp++; if (d !== exp_d[i]) begin n_fail++; $display("FAIL sweep_rpt[%0d] got %h want %h", i, d, exp_d[i]); end
      n_cmp++; if (wrapped_o !== exp_w[i]) begin n_fail++; $display("FAIL sweep_wrapped[%0d] got %b want %b", i, wrapped_o, exp_w[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [32:0] cap; bit found, stable;
    found = 1'b0; stable = 1'b1;
    rpt_ready_i = 1'b0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (rpt_valid_o) found = 1'b1; else step();
    end
    cap = rpt_data_o;
    n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL bp_valid_seen got %b want 1", found); end
    n_cmp++; if (cap !== mk(1'b0, 5, 1)) begin n_fail++; $display("FAIL bp_rpt got %h want %h", cap, mk(1'b0, 5, 1)); end
    for (int c = 0; c < 10; c++) begin
      step();
      if (rpt_valid_o !== 1'b1 || rpt_data_o !== cap) stable = 1'b0;
    end
    n_cmp++; if (stable !== 1'b1) begin n_fail++; $display("FAIL bp_stable got %b want 1", stable); end
    rpt_ready_i = 1'b1;
    step();
    n_cmp++; if (rpt_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop got %b want 0", rpt_valid_o); end
  endtask

  task automatic test_abort();
    logic [32:0] d; int nr, ng, gap; bit tmo, found;
    found = 1'b0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (glitch_out_o) found = 1'b1; else step();
    end
    n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL abort_glitch_seen got %b want 1", found); end
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    n_cmp++; if (glitch_out_o !== 1'b0) begin n_fail++; $display("FAIL abort_glitch got %b want 0", glitch_out_o); end
    n_cmp++; if (rst_out_n_o !== 1'b1) begin n_fail++; $display("FAIL abort_rst_out_n got %b want 1", rst_out_n_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy_o); end
    run_attempt(1'b0, d, nr, ng, gap, tmo);
    n_cmp++; if (d !== mk(1'b0, 5, 3)) begin n_fail++; $display("FAIL abort_retry_rpt got %h want %h", d, mk(1'b0, 5, 3)); end
  endtask

  task automatic test_hit();
    logic [32:0] cap, d; int nr, ng, gap; bit tmo, found;
    found = 1'b0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (glitch_out_o) found = 1'b1; else step();
    end
    dbg_in_i = 8'h88;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (rpt_valid_o) found = 1'b1; else step();
    end
    cap = rpt_data_o;
    dbg_in_i = 8'h00;
    n_cmp++; if (cap !== mk(1'b1, 6, 1)) begin n_fail++; $display("FAIL hit_rpt got %h want %h", cap, mk(1'b1, 6, 1)); end
    step();
    n_cmp++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL hit_done got %b want 1", done_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL hit_busy got %b want 0", busy_o); end
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    n_cmp++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL hit_start_ignored got %b want 1", done_o); end
    n_cmp++; if (rst_out_n_o !== 1'b1) begin n_fail++; $display("FAIL hit_done_rst_out_n got %b want 1", rst_out_n_o); end
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL hit_abort_done got %b want 0", done_o); end
    run_attempt(1'b0, d, nr, ng, gap, tmo);
    n_cmp++; if (d !== mk(1'b0, 6, 1)) begin n_fail++; $display("FAIL hit_no_advance got %h want %h", d, mk(1'b0, 6, 1)); end
  endtask

  task automatic test_clr_start();
    logic [32:0] d; int nr, ng, gap; bit tmo;
    run_attempt(1'b1, d, nr, ng, gap, tmo);
    n_cmp++; if (d !== mk(1'b0, 5, 1)) begin n_fail++; $display("FAIL clr_start_rpt got %h want %h", d, mk(1'b0, 5, 1)); end
  endtask

  task automatic async_reset_mid_wait(input bit want_wrapped_before);
    bit found;
    n_cmp++; if (wrapped_o !== want_wrapped_before) begin n_fail++; $display("FAIL areset_wrapped_before got %b want %b", wrapped_o, want_wrapped_before); end
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (!rst_out_n_o) found = 1'b1; else step();
    end
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (rst_out_n_o) found = 1'b1; else step();
    end
    n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL areset_busy_in_wait got %b want 1", busy_o); end
    rst_n_i = 1'b0;
    #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL areset_busy got %b want 0", busy_o); end
    n_cmp++; if (rst_out_n_o !== 1'b1) begin n_fail++; $display("FAIL areset_rst_out_n got %b want 1", rst_out_n_o); end
    n_cmp++; if (glitch_out_o !== 1'b0) begin n_fail++; $display("FAIL areset_glitch got %b want 0", glitch_out_o); end
    n_cmp++; if (wrapped_o !== 1'b0) begin n_fail++; $display("FAIL areset_wrapped got %b want 0", wrapped_o); end
    n_cmp++; if (rpt_valid_o !== 1'b0) begin n_fail++; $display("FAIL areset_rpt_valid got %b want 0", rpt_valid_o); end
    step();
    rst_n_i = 1'b1;
    step();
  endtask

`ifndef GLITCH_SWEEP_SEQ_AUTORUN_EN
  task automatic test_async_reset();
    logic [32:0] d; int nr, ng, gap; bit tmo;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    async_reset_mid_wait(1'b1);
    run_attempt(1'b0, d, nr, ng, gap, tmo);
    n_cmp++; if (d !== mk(1'b0, 5, 1)) begin n_fail++; $display("FAIL areset_next_rpt got %h want %h", d, mk(1'b0, 5, 1)); end
  endtask
`else
  task automatic test_autorun();
    logic [32:0] exp_d [2];
    logic [32:0] cap;
    bit found;
    exp_d[0] = mk(1'b0, 5, 1);
    exp_d[1] = mk(1'b0, 5, 3);
    rpt_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
        if (rpt_valid_o) found = 1'b1; else step();
      end
      cap = rpt_data_o;
      n_cmp++; if (cap !== exp_d[i]) begin n_fail++; $display("FAIL autorun_rpt[%0d] got %h want %h", i, cap, exp_d[i]); end
      step();
    end
    async_reset_mid_wait(1'b0);
  endtask
`endif

  initial begin
    test_reset();
`ifdef GLITCH_SWEEP_SEQ_AUTORUN_EN
    test_autorun();
`else
    test_latency();
    test_sweep();
    test_backpressure();
    test_abort();
    test_hit();
    test_clr_start();
    test_async_reset();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
